// File: rtl/divider.sv
// divider: counts qualifying ticks on input_clk (level-sampled in the clk
// domain) and emits a one-cycle registered strobe after every COUNT-th tick.
module divider #(
  parameter int unsigned COUNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic input_clk,
  output logic output_pulse
);

  // Counter width; a single bit is kept even for COUNT=1 so the vector is legal.
  localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  // Terminal count; the wrap is explicit here so power-of-two ratios
  // behave exactly like any other ratio.
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  // A zero ratio has no meaning; refuse to build it.
  if (COUNT < 1) begin : g_bad_count
    $fatal(1, "divider: COUNT must be >= 1 (got %0d)", COUNT);
  end

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Tick counter and strobe register; reset discards any partial count
  // and drops a pending or visible pulse immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (input_clk) begin
        if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign output_pulse = r_pulse;

  // The counter must never leave the 0..COUNT-1 range.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= LAST)
    else $error("divider: cnt %0d out of range for COUNT %0d", r_cnt, COUNT);

endmodule

// File: tb/tb_divider.sv
// tb_divider: several divider instances with different ratios share one
// tick stream; a tick-total model predicts every strobe.
module tb_divider;

  localparam int N = 6;
  localparam int unsigned CNTS [N] = '{1, 2, 3, 4, 5, 16};

  logic         clk;
  logic         rst_n;
  logic         input_clk;
  logic [N-1:0] pulse;

  for (genvar g = 0; g < N; g++) begin : g_dut
    divider #(.COUNT(CNTS[g])) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .input_clk    (input_clk),
      .output_pulse (pulse[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model: ticks seen since last reset, and strobe expected this cycle
  int unsigned ticks [N];
  bit          expp  [N];

  task automatic chk(input string tag, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%0b exp=%0b t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      ticks[k] = 0;
      expp[k]  = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_C%0d", tag, CNTS[k]), pulse[k], expp[k]);
  endtask

  // one clock cycle: drive tick, take the edge, update model, compare at edge+1
  task automatic step(input bit tick, input string tag);
    input_clk = tick;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        ticks[k] = 0;
        expp[k]  = 1'b0;
      end else if (tick) begin
        ticks[k]++;
        expp[k] = (ticks[k] % CNTS[k]) == 0;
      end else begin
        expp[k] = 1'b0;
      end
    end
    check_all(tag);
  endtask

  // asynchronous reset between edges; outputs must drop without a clock edge
  task automatic async_reset(input int hold, input bit tick, input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    for (int i = 0; i < hold; i++) step(tick, {tag, "_hold"});
    rst_n = 1'b1;
  endtask

  int npulse;
  bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    rst_n     = 1'b1;
    input_clk = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst");
    step(1'b1, "rst_clk");
    step(1'b1, "rst_clk");
    rst_n = 1'b1;

    // continuous ticks; C3 must strobe exactly 3 times in 10 cycles
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, "cont");
      if (pulse[2]) npulse++;
    end
    chk("c3_pulses_in_10", npulse == 3, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, "cont2");

    // gapped pattern from a clean start
    async_reset(1, 1'b0, "pat_pre");
    for (int i = 0; i < 8; i++) step(pat[i], "pat");
    step(1'b0, "pat_tail");

    // idle stream
    for (int i = 0; i < 20; i++) step(1'b0, "idle");

    // mid-count reset while C1/C2 are strobing
    async_reset(1, 1'b0, "mid_pre");
    step(1'b1, "mid");
    step(1'b1, "mid");
    async_reset(2, 1'b1, "mid");
    for (int i = 0; i < 6; i++) step(1'b1, "mid_post");

    // random ticks with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0)
        async_reset($urandom_range(0, 2), 1'(($urandom_range(0, 1))), "rnd");
      step(1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
